// File: rtl/hum_frame_decoder.sv
// DHT11 frame decoder: detects new frames, checks checksum/range, converts to BCD.
// Optional min/max tracking outputs are enabled with `define HUM_MINMAX_EN.
module hum_frame_decoder #(
  parameter int unsigned HUM_MAX   = 100,
  parameter int unsigned TEMP_MAX  = 50,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk1M,
  input  logic                 rst_n,
  input  logic [39:0]          HYM2,
  output logic [7:0]           hum_bin,
  output logic [7:0]           temp_bin,
  output logic [11:0]          hum_bcd,
  output logic [11:0]          temp_bcd,
  output logic                 data_valid,
  output logic                 crc_err,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef HUM_MINMAX_EN
  ,
  output logic [7:0]           hum_min,
  output logic [7:0]           hum_max,
  output logic [7:0]           temp_min,
  output logic [7:0]           temp_max
`endif
);

  localparam logic [7:0] HumMaxB  = 8'(HUM_MAX);
  localparam logic [7:0] TempMaxB = 8'(TEMP_MAX);
  localparam logic [ERR_CNT_W-1:0] ErrOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCheck, StConv, StDone} state_e;

  state_e                state_q, state_d;
  logic [39:0]           frame_q, frame_d;
  logic [19:0]           hum_sh_q, hum_sh_d;
  logic [19:0]           temp_sh_q, temp_sh_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            hum_bin_q, hum_bin_d;
  logic [7:0]            temp_bin_q, temp_bin_d;
  logic [11:0]           hum_bcd_q, hum_bcd_d;
  logic [11:0]           temp_bcd_q, temp_bcd_d;
  logic                  valid_q, valid_d;
  logic                  crc_q, crc_d;
  logic                  range_q, range_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [7:0]            sum;

`ifdef HUM_MINMAX_EN
  logic       seen_q, seen_d;
  logic [7:0] hum_min_q, hum_min_d, hum_max_q, hum_max_d;
  logic [7:0] temp_min_q, temp_min_d, temp_max_q, temp_max_d;
`endif

  // One double-dabble iteration: add-3 correction on BCD nibbles [19:8], then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  assign sum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    hum_sh_d   = hum_sh_q;
    temp_sh_d  = temp_sh_q;
    cnt_d      = cnt_q;
    hum_bin_d  = hum_bin_q;
    temp_bin_d = temp_bin_q;
    hum_bcd_d  = hum_bcd_q;
    temp_bcd_d = temp_bcd_q;
    valid_d    = 1'b0;
    crc_d      = crc_q;
    range_d    = range_q;
    err_d      = err_q;
`ifdef HUM_MINMAX_EN
    seen_d     = seen_q;
    hum_min_d  = hum_min_q;
    hum_max_d  = hum_max_q;
    temp_min_d = temp_min_q;
    temp_max_d = temp_max_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (HYM2 != frame_q) begin
          frame_d = HYM2;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((sum != frame_q[7:0]) || (frame_q == 40'd0)) begin
          crc_d   = 1'b1;
          range_d = 1'b0;
          if (err_q != '1) err_d = err_q + ErrOne;
          state_d = StIdle;
        end else if ((frame_q[39:32] > HumMaxB) || (frame_q[23:16] > TempMaxB)) begin
          crc_d   = 1'b0;
          range_d = 1'b1;
          if (err_q != '1) err_d = err_q + ErrOne;
          state_d = StIdle;
        end else begin
          hum_sh_d  = {12'd0, frame_q[39:32]};
          temp_sh_d = {12'd0, frame_q[23:16]};
          cnt_d     = 3'd0;
          state_d   = StConv;
        end
      end
      StConv: begin
        hum_sh_d  = dd_step(hum_sh_q);
        temp_sh_d = dd_step(temp_sh_q);
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        // frame_q is stable outside IDLE, so the binary bytes come straight from it.
        hum_bin_d  = frame_q[39:32];
        temp_bin_d = frame_q[23:16];
        hum_bcd_d  = hum_sh_q[19:8];
        temp_bcd_d = temp_sh_q[19:8];
        crc_d      = 1'b0;
        range_d    = 1'b0;
        valid_d    = 1'b1;
        state_d    = StIdle;
`ifdef HUM_MINMAX_EN
        seen_d = 1'b1;
        if (!seen_q) begin
          hum_min_d  = frame_q[39:32];
          hum_max_d  = frame_q[39:32];
          temp_min_d = frame_q[23:16];
          temp_max_d = frame_q[23:16];
        end else begin
          if (frame_q[39:32] < hum_min_q)  hum_min_d  = frame_q[39:32];
          if (frame_q[39:32] > hum_max_q)  hum_max_d  = frame_q[39:32];
          if (frame_q[23:16] < temp_min_q) temp_min_d = frame_q[23:16];
          if (frame_q[23:16] > temp_max_q) temp_max_d = frame_q[23:16];
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      frame_q    <= 40'd0;
      hum_sh_q   <= 20'd0;
      temp_sh_q  <= 20'd0;
      cnt_q      <= 3'd0;
      hum_bin_q  <= 8'd0;
      temp_bin_q <= 8'd0;
      hum_bcd_q  <= 12'd0;
      temp_bcd_q <= 12'd0;
      valid_q    <= 1'b0;
      crc_q      <= 1'b0;
      range_q    <= 1'b0;
      err_q      <= '0;
`ifdef HUM_MINMAX_EN
      seen_q     <= 1'b0;
      hum_min_q  <= 8'hFF;
      hum_max_q  <= 8'h00;
      temp_min_q <= 8'hFF;
      temp_max_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      hum_sh_q   <= hum_sh_d;
      temp_sh_q  <= temp_sh_d;
      cnt_q      <= cnt_d;
      hum_bin_q  <= hum_bin_d;
      temp_bin_q <= temp_bin_d;
      hum_bcd_q  <= hum_bcd_d;
      temp_bcd_q <= temp_bcd_d;
      valid_q    <= valid_d;
      crc_q      <= crc_d;
      range_q    <= range_d;
      err_q      <= err_d;
`ifdef HUM_MINMAX_EN
      seen_q     <= seen_d;
      hum_min_q  <= hum_min_d;
      hum_max_q  <= hum_max_d;
      temp_min_q <= temp_min_d;
      temp_max_q <= temp_max_d;
`endif
    end
  end

  assign hum_bin    = hum_bin_q;
  assign temp_bin   = temp_bin_q;
  assign hum_bcd    = hum_bcd_q;
  assign temp_bcd   = temp_bcd_q;
  assign data_valid = valid_q;
  assign crc_err    = crc_q;
  assign range_err  = range_q;
  assign err_cnt    = err_q;
`ifdef HUM_MINMAX_EN
  assign hum_min    = hum_min_q;
  assign hum_max    = hum_max_q;
  assign temp_min   = temp_min_q;
  assign temp_max   = temp_max_q;
`endif

endmodule

// File: tb/tb_hum_frame_decoder.sv
// Directed bench for hum_frame_decoder; drives on and samples at the falling clock edge.
module tb_hum_frame_decoder;

  logic        clk1M = 1'b0;
  logic        rst_n;
  logic [39:0] HYM2;
  logic [7:0]  hum_bin, temp_bin;
  logic [11:0] hum_bcd, temp_bcd;
  logic        data_valid, crc_err, range_err;
  logic [7:0]  err_cnt;
`ifdef HUM_MINMAX_EN
  logic [7:0]  hum_min, hum_max, temp_min, temp_max;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  always #500 clk1M = ~clk1M;

  hum_frame_decoder dut (
    .clk1M      (clk1M),
    .rst_n      (rst_n),
    .HYM2       (HYM2),
    .hum_bin    (hum_bin),
    .temp_bin   (temp_bin),
    .hum_bcd    (hum_bcd),
    .temp_bcd   (temp_bcd),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .range_err  (range_err),
    .err_cnt    (err_cnt)
`ifdef HUM_MINMAX_EN
    ,
    .hum_min    (hum_min),
    .hum_max    (hum_max),
    .temp_min   (temp_min),
    .temp_max   (temp_max)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk1M);
  endtask

  // Advance n cycles, counting data_valid pulses seen at each falling edge.
  task automatic count_dv(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk1M);
      if (data_valid) cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    HYM2  = 40'd0;
    cyc(3);
    chk("rst_hum_bin", 32'(hum_bin), 32'h0);
    chk("rst_temp_bcd", 32'(temp_bcd), 32'h0);
    chk("rst_flags", {29'd0, data_valid, crc_err, range_err}, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
`ifdef HUM_MINMAX_EN
    chk("rst_hum_min", 32'(hum_min), 32'hFF);
    chk("rst_hum_max", 32'(hum_max), 32'h00);
`endif
    rst_n = 1'b1;
    cyc(2);

    // Valid frame: hum 50, temp 25; pulse after 11 edges counting the detection edge.
    HYM2 = 40'h320019004B;
    cyc(10);
    chk("v1_dv_early", 32'(data_valid), 32'h0);
    cyc(1);
    chk("v1_dv", 32'(data_valid), 32'h1);
    chk("v1_hum_bin", 32'(hum_bin), 32'd50);
    chk("v1_hum_bcd", 32'(hum_bcd), 32'h050);
    chk("v1_temp_bin", 32'(temp_bin), 32'd25);
    chk("v1_temp_bcd", 32'(temp_bcd), 32'h025);
    chk("v1_flags", {30'd0, crc_err, range_err}, 32'h0);
    cyc(1);
    chk("v1_dv_one", 32'(data_valid), 32'h0);

    // Bad checksum.
    HYM2 = 40'h320019004C;
    cyc(2);
    chk("crc_flag", {30'd0, crc_err, range_err}, 32'h2);
    chk("crc_err_cnt", 32'(err_cnt), 32'd1);
    chk("crc_hold_bcd", 32'(hum_bcd), 32'h050);
    count_dv(12, pulses);
    chk("crc_no_dv", 32'(pulses), 32'd0);

    // Humidity 101 out of range, then valid 30/20.
    HYM2 = 40'h6500140079;
    cyc(2);
    chk("rng_flag", {30'd0, crc_err, range_err}, 32'h1);
    chk("rng_err_cnt", 32'(err_cnt), 32'd2);
    HYM2 = 40'h1E00140032;
    cyc(11);
    chk("v2_dv", 32'(data_valid), 32'h1);
    chk("v2_hum_bcd", 32'(hum_bcd), 32'h030);
    chk("v2_temp_bcd", 32'(temp_bcd), 32'h020);
    chk("v2_flags", {30'd0, crc_err, range_err}, 32'h0);

    // Same frame re-applied: only one pulse.
    cyc(2);
    HYM2 = 40'h2D00170044;
    count_dv(12, pulses);
    HYM2 = 40'h2D00170044;
    begin
      int more;
      count_dv(13, more);
      pulses += more;
    end
    chk("dup_pulses", 32'(pulses), 32'd1);
    chk("dup_hum_bcd", 32'(hum_bcd), 32'h045);

    // Change during CONV: old frame completes, new one follows.
    HYM2 = 40'h0A0005000F;
    cyc(4);
    HYM2 = 40'h4B00280073;
    cyc(7);
    chk("mid_dv1", 32'(data_valid), 32'h1);
    chk("mid_hum_bcd1", 32'(hum_bcd), 32'h010);
    chk("mid_temp_bcd1", 32'(temp_bcd), 32'h005);
    cyc(10);
    chk("mid_dv2_early", 32'(data_valid), 32'h0);
    cyc(1);
    chk("mid_dv2", 32'(data_valid), 32'h1);
    chk("mid_hum_bin2", 32'(hum_bin), 32'h4B);
    chk("mid_hum_bcd2", 32'(hum_bcd), 32'h075);
    chk("mid_temp_bcd2", 32'(temp_bcd), 32'h040);

    // Error counter saturation: 2 + 253 = 255, then 7 more must not wrap.
    for (int i = 0; i < 253; i++) begin
      HYM2 = i[0] ? 40'h320019004D : 40'h320019004C;
      cyc(2);
    end
    chk("sat_reach", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 7; i++) begin
      HYM2 = i[0] ? 40'h320019004C : 40'h320019004D;
      cyc(2);
    end
    chk("sat_hold", 32'(err_cnt), 32'd255);
    chk("sat_hold_bin", 32'(hum_bin), 32'h4B);

    // All-zero frame is a checksum error even though the sum matches.
    HYM2 = 40'h6500140079;
    cyc(2);
    chk("pre_zero_rng", {30'd0, crc_err, range_err}, 32'h1);
    HYM2 = 40'h0;
    cyc(2);
    chk("zero_crc", {30'd0, crc_err, range_err}, 32'h2);

    // Reset during CONV aborts with no pulse.
    HYM2 = 40'h1E00140032;
    cyc(5);
    rst_n = 1'b0;
    HYM2  = 40'h0;
    cyc(1);
    chk("abort_hum_bin", 32'(hum_bin), 32'h0);
    chk("abort_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    count_dv(15, pulses);
    chk("abort_no_dv", 32'(pulses), 32'd0);
    chk("abort_bcd", {8'd0, hum_bcd, temp_bcd}, 32'h0);

`ifdef HUM_MINMAX_EN
    HYM2 = 40'h280014003C;
    cyc(12);
    HYM2 = 40'h3C00140050;
    cyc(12);
    HYM2 = 40'h1E00140032;
    cyc(12);
    chk("mm_hum_min", 32'(hum_min), 32'd30);
    chk("mm_hum_max", 32'(hum_max), 32'd60);
    chk("mm_temp_min", 32'(temp_min), 32'd20);
    chk("mm_temp_max", 32'(temp_max), 32'd20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
